branch_predictor: RTL
=====================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of table entries (power of two, >=2); IDX_W = log2(ENTRIES).
REQ-002 SHALL have parameter TAG_W, default 8, number of tag bits stored per entry.
REQ-003 SHALL have parameter CNT_W, default 2, width of the saturating direction counter (>=1).
REQ-004 SHALL have one clock and a synchronous, active-high reset; ports clk and reset.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 PCF  input  32  fetch-stage PC to predict.
REQ-008 PredTakenF  output  1  prediction for PCF: taken.
REQ-009 PredTargetF  output  32  predicted next PC for PCF.
REQ-010 UpdateE  input  1  a branch or jump resolves in Execute this cycle.
REQ-011 PCE  input  32  PC of the resolving instruction.
REQ-012 ActualTakenE  input  1  resolved direction (1 for every jump).
REQ-013 ActualTargetE  input  32  resolved taken target.
REQ-014 PredTakenE, PredTargetE  input  1/32  prediction made at fetch, carried through the pipeline.
REQ-015 MispredictE  output  1  the resolving instruction was mispredicted; drives flush of F/D.
REQ-016 CorrectPCE  output  32  PC to redirect to on a mispredict.
REQ-017 MispredCount  output  32  count of mispredicts since reset.

Function
REQ-018 Index = PC[IDX_W+1:2]; tag = PC[IDX_W+TAG_W+1:IDX_W+2]; PC[1:0] SHALL be ignored.
REQ-019 Each entry SHALL hold valid (1b), tag (TAG_W), target (32), counter (CNT_W).
REQ-020 Hit = valid and stored tag == tag(PCF); lookup SHALL be combinational from the registered table (zero latency).
REQ-021 PredTakenF = hit and counter MSB; PredTargetF = stored target when PredTakenF, else PCF+4 (mod 2^32).
REQ-022 MispredictE = UpdateE and (ActualTakenE != PredTakenE, or both taken and ActualTargetE != PredTargetE); 0 when UpdateE=0.
REQ-023 CorrectPCE = ActualTakenE ? ActualTargetE : PCE+4, regardless of MispredictE.
REQ-024 On UpdateE with tag hit at idx(PCE): counter +1 if taken, -1 if not, saturating at 2^CNT_W-1 and 0; target <- ActualTargetE if taken, unchanged otherwise.
REQ-025 On UpdateE with tag miss and ActualTakenE=1: entry SHALL be replaced: valid<-1, tag<-tag(PCE), target<-ActualTargetE, counter<-2^(CNT_W-1) (weakly taken).
REQ-026 On UpdateE with tag miss and ActualTakenE=0: table SHALL be unchanged.
REQ-027 Same-cycle lookup and update of the same index: lookup SHALL return pre-update contents; the update is visible from the next cycle.
REQ-028 MispredCount SHALL increment by 1 on each cycle with MispredictE=1 and wrap from 2^32-1 to 0.
REQ-029 Only one update per cycle; no internal stall or backpressure; block SHALL accept UpdateE every cycle.

Reset
REQ-030 reset=1 at a rising edge SHALL clear all valid bits, set all counters to 2^(CNT_W-1)-1 (weakly not-taken), zero targets/tags and zero MispredCount; UpdateE SHALL be ignored that cycle.
REQ-031 After reset, PredTakenF=0 and PredTargetF=PCF+4 for every PCF; MispredictE remains combinational on its inputs.
REQ-032 Reset mid-sequence SHALL discard all learned state; no partial update of the in-flight entry.

Verification
REQ-033 After reset, PCF=0x100 -> PredTakenF=0, PredTargetF=0x104, MispredCount=0.
REQ-034 UpdateE, PCE=0x100, taken to 0x80, PredTakenE=0 -> MispredictE=1, CorrectPCE=0x80; next cycle PCF=0x100 -> PredTakenF=1, PredTargetF=0x80, MispredCount=1.
REQ-035 (CNT_W=2) Three taken updates at 0x100 then two not-taken -> counter 2,3,3,2,1; PredTakenF 1,1,1,1,0 after each update.
REQ-036 Alias: entry trained at 0x100, lookup PCF=0x140 (same index, ENTRIES=16, different tag) -> PredTakenF=0; not-taken update at 0x140 leaves 0x100 entry intact; taken update at 0x140 evicts it.
REQ-037 Same-cycle update and lookup of 0x100 -> lookup returns old prediction; new one next cycle.
REQ-038 Assert reset after training -> all lookups not-taken, MispredCount=0; ENTRIES=4, CNT_W=1 build passes REQ-033..REQ-035 with CNT_W=1 saturating counter values.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is combinational from the registered table; resolution updates it one cycle later.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    output logic        PredTakenF,
    output logic [31:0] PredTargetF,
    input  logic        UpdateE,
    input  logic [31:0] PCE,
    input  logic        ActualTakenE,
    input  logic [31:0] ActualTargetE,
    input  logic        PredTakenE,
    input  logic [31:0] PredTargetE,
    output logic        MispredictE,
    output logic [31:0] CorrectPCE,
    output logic [31:0] MispredCount
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_WEAK_T = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WEAK_N = CNT_WEAK_T - CNT_W'(1);

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [CNT_W-1:0] cnt_q    [ENTRIES];
    logic [31:0]      mispredCount_q;

    logic [IDX_W-1:0] idxF;
    logic [TAG_W-1:0] tagF;
    logic             hitF;
    logic [IDX_W-1:0] idxE;
    logic [TAG_W-1:0] tagE;
    logic             hitE;

    logic             wrEn_d;
    logic [CNT_W-1:0] cnt_d;
    logic [31:0]      target_d;

    assign idxF = PCF[IDX_W+1:2];
    assign tagF = PCF[IDX_W+TAG_W+1:IDX_W+2];
    assign idxE = PCE[IDX_W+1:2];
    assign tagE = PCE[IDX_W+TAG_W+1:IDX_W+2];

    assign hitF = valid_q[idxF] && (tag_q[idxF] == tagF);
    assign hitE = valid_q[idxE] && (tag_q[idxE] == tagE);

    assign PredTakenF  = hitF && cnt_q[idxF][CNT_W-1];
    assign PredTargetF = PredTakenF ? target_q[idxF] : PCF + 32'd4;

    // A taken/taken pair still mispredicts if the carried target was stale.
    assign MispredictE = UpdateE &&
                         ((ActualTakenE != PredTakenE) ||
                          (ActualTakenE && PredTakenE && (ActualTargetE != PredTargetE)));
    assign CorrectPCE  = ActualTakenE ? ActualTargetE : PCE + 32'd4;
    assign MispredCount = mispredCount_q;

    // Not-taken misses allocate nothing, so they never evict a useful entry.
    always_comb begin
        wrEn_d   = 1'b0;
        cnt_d    = cnt_q[idxE];
        target_d = target_q[idxE];
        if (UpdateE) begin
            if (hitE) begin
                wrEn_d = 1'b1;
                if (ActualTakenE) begin
                    target_d = ActualTargetE;
                    if (cnt_q[idxE] != CNT_MAX) begin
                        cnt_d = cnt_q[idxE] + CNT_W'(1);
                    end
                end else if (cnt_q[idxE] != '0) begin
                    cnt_d = cnt_q[idxE] - CNT_W'(1);
                end
            end else if (ActualTakenE) begin
                wrEn_d   = 1'b1;
                cnt_d    = CNT_WEAK_T;
                target_d = ActualTargetE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_WEAK_N;
            end
            mispredCount_q <= '0;
        end else begin
            if (wrEn_d) begin
                valid_q[idxE]  <= 1'b1;
                tag_q[idxE]    <= tagE;
                target_q[idxE] <= target_d;
                cnt_q[idxE]    <= cnt_d;
            end
            if (MispredictE) begin
                mispredCount_q <= mispredCount_q + 32'd1;
            end
        end
    end

endmodule
